bus_cycle_ctrl: RTL
===================

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_SPLIT, default 20'h80000, the first memory address decoded to MEM2; lower addresses decode to MEM1.
REQ-002 SHALL have parameter IO1_BASE, default 16'hFF00, the base of the 256-byte IO1 window (IO1_BASE..IO1_BASE+16'h00FF).
REQ-003 SHALL have parameter IO2_BASE, default 16'h1C00, the base of the 512-byte IO2 window (IO2_BASE..IO2_BASE+16'h01FF).
REQ-004 SHALL have parameters WS_MEM1, WS_MEM2, WS_IO1, WS_IO2, each 2 bits, defaults 0, 1, 2, 3, giving the wait-state count per region.
REQ-005 SHALL have parameter STB_TIMEOUT, default 4, the maximum number of cycles in ADDR without a strobe.
REQ-006 Port list:
- CLK  in  1  bus clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ALE  in  1  address latch enable, high in T1.
- IOM  in  1  1 = IO cycle, 0 = memory cycle.
- Address  in  20  multiplexed bus address; only [15:0] is used for IO cycles.
- RD  in  1  read strobe, active-low.
- WR  in  1  write strobe, active-low.
- CS  out  4  one-hot chip selects: [0] MEM1, [1] MEM2, [2] IO1, [3] IO2.
- READY  out  1  high = the cycle may complete.
- BUS_ERR  out  1  one-cycle error pulse.

Function
REQ-007 SHALL implement the FSM states IDLE, ADDR, WAIT, DONE, HOLD.
REQ-008 In IDLE with ALE=1, SHALL decode Address/IOM, register the region into CS (or 4'b0000 if unmapped), and go to ADDR; ALE seen in any other state SHALL be ignored.
REQ-009 Decode rules:
- Memory cycle: Address < MEM_SPLIT -> MEM1, otherwise MEM2.
- IO cycle: Address[15:0] in the IO1 window -> IO1; in the IO2 window -> IO2.
- Address[19:16] SHALL be ignored for IO cycles.
- If both IO windows match, IO1 SHALL win.
REQ-010 In ADDR with exactly one strobe low:
- Load the 2-bit wait counter with the region's WS value.
- Go to WAIT if WS>0, or to DONE if WS=0.
REQ-011 In WAIT, SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reads 1; READY SHALL be 0 in ADDR and WAIT.
REQ-012 Read/write strobe to READY latency SHALL be WS+1 cycles: READY high in DONE for exactly one cycle, then go to HOLD.
REQ-013 In HOLD, READY SHALL be 0, and the FSM SHALL return to IDLE when RD=1 and WR=1, clearing CS on that transition.
REQ-014 Unmapped cycle: in ADDR with a strobe low, SHALL pulse BUS_ERR for one cycle and go directly to DONE with CS=0.
REQ-015 RD=0 and WR=0 together in ADDR SHALL pulse BUS_ERR, clear CS, and go to HOLD without asserting READY.
REQ-016 If no strobe arrives within STB_TIMEOUT cycles of entering ADDR, SHALL pulse BUS_ERR, clear CS, and go to IDLE.
REQ-017 A strobe deasserted during WAIT SHALL abort the cycle: pulse BUS_ERR, clear CS, go to IDLE.
REQ-018 CS SHALL remain stable from ADDR through HOLD and never have more than one bit set.

Reset
REQ-019 RESET=0 SHALL immediately force IDLE, CS=4'b0000, READY=0, BUS_ERR=0, counter=0, regardless of clock.
REQ-020 Reset asserted mid-cycle SHALL abandon the cycle; after release, the FSM SHALL wait for a fresh ALE.

Verification
REQ-021 ALE, IOM=0, Address=20'h00100, then RD=0 -> CS=4'b0001, READY=1 in the cycle after the strobe, CS=0 after RD=1.
REQ-022 ALE, IOM=0, Address=20'h80010, then WR=0 -> CS=4'b0010, READY low 1 cycle, then high 1 cycle (latency 2).
REQ-023 ALE, IOM=1, Address=20'hAFF20, then RD=0 -> CS=4'b0100 (upper bits ignored), READY after 3 cycles; IOM=1, Address=16'h1D00 -> CS=4'b1000, READY after 4 cycles.
REQ-024 ALE, IOM=1, Address=16'h0040, then RD=0 -> CS=0, BUS_ERR one-cycle pulse, READY=1 one cycle.
REQ-025 ALE, then no strobe for 4 cycles -> BUS_ERR pulse, IDLE; ALE, then RD=0 and WR=0 together -> BUS_ERR, READY never high.
REQ-026 RESET low during WAIT of an IO2 cycle -> CS=0 and READY=0 asynchronously; the next ALE cycle completes normally.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: decodes a latched address into one-hot chip selects and
// sequences strobe, wait states, READY and BUS_ERR for each bus cycle.
module bus_cycle_ctrl #(
    parameter logic [19:0] MEM_SPLIT   = 20'h80000,
    parameter logic [15:0] IO1_BASE    = 16'hFF00,
    parameter logic [15:0] IO2_BASE    = 16'h1C00,
    parameter logic [1:0]  WS_MEM1     = 2'd0,
    parameter logic [1:0]  WS_MEM2     = 2'd1,
    parameter logic [1:0]  WS_IO1      = 2'd2,
    parameter logic [1:0]  WS_IO2      = 2'd3,
    parameter int unsigned STB_TIMEOUT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic [19:0] Address,
    input  logic        RD,
    input  logic        WR,
    output logic [3:0]  CS,
    output logic        READY,
    output logic        BUS_ERR
);

    localparam int TW = (STB_TIMEOUT < 2) ? 1 : $clog2(STB_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(STB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cs_q, cs_d;
    logic            ready_q, ready_d;
    logic            bus_err_q, bus_err_d;
    logic [1:0]      wcnt_q, wcnt_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            one_stb_s, both_stb_s, no_stb_s;
    logic [1:0]      ws_s;

    // Window tests use wrap-around offsets so each window is a single compare.
    function automatic logic [3:0] decode(input logic iom, input logic [19:0] addr);
        logic [15:0] off1;
        logic [15:0] off2;
        off1 = addr[15:0] - IO1_BASE;
        off2 = addr[15:0] - IO2_BASE;
        if (!iom) begin
            decode = (addr < MEM_SPLIT) ? 4'b0001 : 4'b0010;
        end else if (off1 < 16'h0100) begin
            decode = 4'b0100;
        end else if (off2 < 16'h0200) begin
            decode = 4'b1000;
        end else begin
            decode = 4'b0000;
        end
    endfunction

    function automatic logic [1:0] ws_of(input logic [3:0] cs);
        case (cs)
            4'b0001: ws_of = WS_MEM1;
            4'b0010: ws_of = WS_MEM2;
            4'b0100: ws_of = WS_IO1;
            4'b1000: ws_of = WS_IO2;
            default: ws_of = 2'd0;
        endcase
    endfunction

    assign one_stb_s  = RD ^ WR;
    assign both_stb_s = !RD && !WR;
    assign no_stb_s   = RD && WR;
    assign ws_s       = ws_of(cs_q);

    // Next-state and registered-output logic for the bus cycle FSM.
    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;
        ready_d   = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ALE) begin
                    cs_d    = decode(IOM, Address);
                    tcnt_d  = '0;
                    state_d = ADDR;
                end else begin
                    cs_d    = 4'b0000;
                end
            end
            ADDR: begin
                if (both_stb_s) begin
                    bus_err_d = 1'b1;
                    cs_d      = 4'b0000;
                    state_d   = HOLD;
                end else if (one_stb_s) begin
                    if (cs_q == 4'b0000) begin
                        bus_err_d = 1'b1;
                        ready_d   = 1'b1;
                        state_d   = DONE;
                    end else if (ws_s == 2'd0) begin
                        ready_d   = 1'b1;
                        state_d   = DONE;
                    end else begin
                        wcnt_d    = ws_s;
                        state_d   = WAIT;
                    end
                end else if (tcnt_q == TMO_LAST) begin
                    bus_err_d = 1'b1;
                    cs_d      = 4'b0000;
                    state_d   = IDLE;
                end else begin
                    tcnt_d    = tcnt_q + TW'(1);
                end
            end
            WAIT: begin
                // Releasing the strobe before the wait states elapse aborts the cycle.
                if (no_stb_s) begin
                    bus_err_d = 1'b1;
                    cs_d      = 4'b0000;
                    wcnt_d    = 2'd0;
                    state_d   = IDLE;
                end else if (wcnt_q == 2'd1) begin
                    wcnt_d    = 2'd0;
                    ready_d   = 1'b1;
                    state_d   = DONE;
                end else begin
                    wcnt_d    = wcnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (no_stb_s) begin
                    cs_d    = 4'b0000;
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                cs_d    = 4'b0000;
                wcnt_d  = 2'd0;
                tcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by RESET.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cs_q      <= 4'b0000;
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
            wcnt_q    <= 2'd0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            ready_q   <= ready_d;
            bus_err_q <= bus_err_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign CS      = cs_q;
    assign READY   = ready_q;
    assign BUS_ERR = bus_err_q;

endmodule
